// File: rtl/vm_controller.sv
// Control FSM for a no-change vending machine: edge-detects coins, pulses the
// accumulator load/clear and holds the dispense strobe. Optional idle timeout under `TIMEOUT_EN.
module vm_controller #(
    parameter int DISP_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TW             = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       c,
    input  logic       h,
    output logic       ld,
    output logic       clr,
    output logic       d,
    output logic       tout,
    output logic [2:0] state_o
);

    localparam int DW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_WAIT = 3'd1,
        S_ADD  = 3'd2,
        S_DISP = 3'd3
`ifdef TIMEOUT_EN
        , S_TOUT = 3'd4
`endif
    } state_t;

    state_t        state_q, state_d;
    logic          c_q;
    logic          seen_q, seen_d;
    logic [DW-1:0] disp_q, disp_d;
    logic          cr;

    assign cr = c & ~c_q;

`ifdef TIMEOUT_EN
    logic [TW-1:0] idle_q, idle_d;
    logic          hit;

    assign hit = (idle_q == TW'(TIMEOUT_CYCLES - 1));
`else
    logic [TW-1:0] unused_timeout_cfg;

    assign unused_timeout_cfg = TW'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            c_q     <= 1'b0;
            seen_q  <= 1'b0;
            disp_q  <= '0;
`ifdef TIMEOUT_EN
            idle_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            c_q     <= c;
            seen_q  <= seen_d;
            disp_q  <= disp_d;
`ifdef TIMEOUT_EN
            idle_q  <= idle_d;
`endif
        end
    end

    // A vend needs both h and at least one loaded coin; a coin in the winning cycle is lost.
    always_comb begin
        state_d = state_q;
        seen_d  = seen_q;
        disp_d  = disp_q;
`ifdef TIMEOUT_EN
        idle_d  = idle_q;
`endif
        case (state_q)
            S_INIT: begin
                state_d = S_WAIT;
                seen_d  = 1'b0;
                disp_d  = '0;
`ifdef TIMEOUT_EN
                idle_d  = '0;
`endif
            end
            S_WAIT: begin
                if (h && seen_q) begin
                    state_d = S_DISP;
                    disp_d  = '0;
                end else if (cr) begin
                    state_d = S_ADD;
                    seen_d  = 1'b1;
                end
`ifdef TIMEOUT_EN
                else if (seen_q) begin
                    if (hit) begin
                        state_d = S_TOUT;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
`endif
            end
            S_ADD: begin
                state_d = S_WAIT;
`ifdef TIMEOUT_EN
                idle_d  = '0;
`endif
            end
            S_DISP: begin
                if (disp_q == DW'(DISP_CYCLES - 1)) begin
                    state_d = S_INIT;
                end else begin
                    disp_d = disp_q + 1'b1;
                end
            end
`ifdef TIMEOUT_EN
            S_TOUT: begin
                state_d = S_WAIT;
                seen_d  = 1'b0;
                idle_d  = '0;
            end
`endif
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign ld      = (state_q == S_ADD);
    assign d       = (state_q == S_DISP);
`ifdef TIMEOUT_EN
    assign tout    = (state_q == S_TOUT);
`else
    assign tout    = 1'b0;
`endif
    assign clr     = (state_q == S_INIT) | tout;
    assign state_o = state_q;

endmodule

// File: tb/tb_vm_controller.sv
// Bench for vm_controller: stub accumulator (price 150), randomized coins/resets
// and forced h, checked every cycle against an output-level behavioural model.
module tb_vm_controller;

    localparam int DISP   = 4;
    localparam int TOUT_N = 16;
    localparam int PRICE  = 150;

    logic       clk = 1'b0;
    logic       rst;
    logic       c;
    logic       h;
    logic       ld;
    logic       clr;
    logic       d;
    logic       tout;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    vm_controller #(
        .DISP_CYCLES    (DISP),
        .TIMEOUT_CYCLES (TOUT_N),
        .TW             (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .c       (c),
        .h       (h),
        .ld      (ld),
        .clr     (clr),
        .d       (d),
        .tout    (tout),
        .state_o (state_o)
    );

    int checks   = 0;
    int failures = 0;

    // stub datapath
    int tot      = 0;
    int cur_coin = 0;
    bit force_h  = 1'b0;

    // reference model: expected outputs of the current cycle plus bookkeeping
    bit m_ld, m_clr, m_d, m_tout;
    bit m_prev_c, m_seen;
    int m_disp_left, m_idle;

    int n_ld, n_d, n_tout;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Predicts the outputs after the coming clock edge from the inputs sampled at it.
    task automatic model_step(input bit cv, input bit hv, input bit rv);
        bit cr;
        bit n_ld_v, n_clr_v, n_d_v, n_tout_v;
        n_ld_v = 0; n_clr_v = 0; n_d_v = 0; n_tout_v = 0;
        if (rv) begin
            n_clr_v  = 1;
            m_seen   = 0;
            m_prev_c = 0;
            m_idle   = 0;
        end else begin
            cr       = cv & ~m_prev_c;
            m_prev_c = cv;
            if (m_clr) begin
                m_seen = 0;
                m_idle = 0;
            end else if (m_ld) begin
                m_idle = 0;
            end else if (m_d) begin
                m_disp_left--;
                if (m_disp_left == 0) n_clr_v = 1;
                else n_d_v = 1;
            end else if (hv && m_seen) begin
                n_d_v       = 1;
                m_disp_left = DISP;
            end else if (cr) begin
                n_ld_v = 1;
                m_seen = 1;
            end else begin
`ifdef TIMEOUT_EN
                if (m_seen) begin
                    m_idle++;
                    if (m_idle == TOUT_N) begin
                        n_clr_v  = 1;
                        n_tout_v = 1;
                    end
                end
`endif
            end
        end
        m_ld = n_ld_v; m_clr = n_clr_v; m_d = n_d_v; m_tout = n_tout_v;
    endtask

    task automatic cycle(input bit cv, input bit rv);
        c   = cv;
        rst = rv;
        h   = force_h | (tot >= PRICE);
        model_step(cv, h, rv);
        @(negedge clk);
        check_eq("ld",   32'(ld),   32'(m_ld));
        check_eq("clr",  32'(clr),  32'(m_clr));
        check_eq("d",    32'(d),    32'(m_d));
        check_eq("tout", 32'(tout), 32'(m_tout));
        check_eq("excl", 32'(int'(ld) + int'(clr) + int'(d)),
                 32'(int'(m_ld) + int'(m_clr) + int'(m_d)));
        if (ld === 1'b1) n_ld++;
        if (d === 1'b1) n_d++;
        if (tout === 1'b1) n_tout++;
        if (clr === 1'b1) tot = 0;
        else if (ld === 1'b1) tot += cur_coin;
    endtask

    task automatic coin(input int val, input int hold, input int gap);
        cur_coin = val;
        repeat (hold) cycle(1'b1, 1'b0);
        repeat (gap) cycle(1'b0, 1'b0);
    endtask

    task automatic wait_d();
        for (int i = 0; i < 20 && !m_d; i++) cycle(1'b0, 1'b0);
        check_eq("wait_d", 32'(d), 32'd1);
    endtask

    int ld0, d0, t0;
    int r;

    initial begin
        c = 1'b0; rst = 1'b1; h = 1'b0;
        m_ld = 0; m_clr = 0; m_d = 0; m_tout = 0;
        m_prev_c = 0; m_seen = 0; m_disp_left = 0; m_idle = 0;
        n_ld = 0; n_d = 0; n_tout = 0;

        // reset: clr for one cycle after release, then idle
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        check_eq("rst_clr", 32'(clr), 32'd1);
        repeat (4) cycle(1'b0, 1'b0);
        check_eq("idle_clr", 32'(clr), 32'd0);

        // 100 then 50: two loads, four dispense cycles
        ld0 = n_ld; d0 = n_d;
        coin(100, 3, 2);
        coin(50, 3, 10);
        check_eq("t2_ld_count", 32'(n_ld - ld0), 32'd2);
        check_eq("t2_d_count",  32'(n_d - d0),   32'd4);
        check_eq("t2_tot",      32'(tot),        32'd0);

        // h forced without a coin: no vend until a coin is loaded
        ld0 = n_ld; d0 = n_d;
        force_h = 1'b1;
        repeat (6) cycle(1'b0, 1'b0);
        check_eq("t3_no_d",  32'(n_d - d0),  32'd0);
        check_eq("t3_no_ld", 32'(n_ld - ld0), 32'd0);
        coin(25, 1, 8);
        check_eq("t3_d_count", 32'(n_d - d0), 32'd4);
        force_h = 1'b0;
        repeat (3) cycle(1'b0, 1'b0);

        // coin edge during dispense is lost
        ld0 = n_ld;
        coin(100, 2, 1);
        coin(50, 1, 0);
        wait_d();
        cur_coin = 100;
        cycle(1'b1, 1'b0);
        repeat (8) cycle(1'b0, 1'b0);
        check_eq("t4_ld_count", 32'(n_ld - ld0), 32'd2);
        check_eq("t4_tot",      32'(tot),        32'd0);

        // single 50 coin then idle: discarded only when the timeout is built in
        t0 = n_tout;
        coin(50, 1, 25);
        coin(100, 1, 0);
`ifdef TIMEOUT_EN
        check_eq("t5_tout_count", 32'(n_tout - t0), 32'd1);
        check_eq("t5_fresh_tot",  32'(tot),         32'd100);
`else
        check_eq("t5_tout_count", 32'(n_tout - t0), 32'd0);
        check_eq("t5_fresh_tot",  32'(tot),         32'd150);
`endif
        repeat (10) cycle(1'b0, 1'b0);
        check_eq("t5_settled", 32'(d | ld), 32'd0);

        // reset during the second dispense cycle
        coin(100, 1, 1);
        coin(50, 1, 0);
        wait_d();
        cycle(1'b0, 1'b0);
        check_eq("t6_d2", 32'(d), 32'd1);
        cycle(1'b0, 1'b1);
        check_eq("t6_d_abort", 32'(d),   32'd0);
        check_eq("t6_clr",     32'(clr), 32'd1);
        repeat (3) cycle(1'b0, 1'b0);

        // randomized coins, forced h toggles and resets
        repeat (220) begin
            r = int'($urandom_range(0, 99));
            if (r < 6) begin
                repeat ($urandom_range(1, 2)) cycle(1'b0, 1'b1);
            end else if (r < 14) begin
                force_h = ~force_h;
                cycle(1'b0, 1'b0);
            end else begin
                case ($urandom_range(0, 2))
                    0: coin(25,  int'($urandom_range(1, 4)), int'($urandom_range(1, 20)));
                    1: coin(50,  int'($urandom_range(1, 4)), int'($urandom_range(1, 20)));
                    default: coin(100, int'($urandom_range(1, 4)), int'($urandom_range(1, 20)));
                endcase
            end
        end
        force_h = 1'b0;
        repeat (10) cycle(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
